// File: rtl/cpu_seq_pkg.sv
// cpu_seq_pkg: slot indices and encodings shared by the fetch sequencer and its users
package cpu_seq_pkg;
  localparam int FETCH_LO = 0;
  localparam int FETCH_HI = 1;
  localparam int EXEC_FIRST = 2;
  localparam logic IR_LOW = 1'b0;
  localparam logic IR_HIGH = 1'b1;
  localparam logic MEM_SEL = 1'b0;
endpackage

// File: rtl/instr_fetch_sequencer_if.sv
// instr_fetch_sequencer_if: control inputs and timing/fetch outputs of the sequencer
interface instr_fetch_sequencer_if #(
  parameter int T_WIDTH = 12,
  parameter int ICNT_WIDTH = 16
);
  logic i_t_reset;
  logic i_stall;
  logic i_halt;
  logic [T_WIDTH-1:0] o_t;
  logic o_ir_write;
  logic o_ir_lh;
  logic o_mem_cs;
  logic o_mem_wr;
  logic o_fetch_pc_inc;
  logic o_fetch_addr_pc;
  logic o_halted;
  logic o_seq_overflow;
  logic [ICNT_WIDTH-1:0] o_instr_count;
  modport master (
    output i_t_reset, i_stall, i_halt,
    input o_t, o_ir_write, o_ir_lh, o_mem_cs, o_mem_wr, o_fetch_pc_inc,
    input o_fetch_addr_pc, o_halted, o_seq_overflow, o_instr_count
  );
  modport slave (
    input i_t_reset, i_stall, i_halt,
    output o_t, o_ir_write, o_ir_lh, o_mem_cs, o_mem_wr, o_fetch_pc_inc,
    output o_fetch_addr_pc, o_halted, o_seq_overflow, o_instr_count
  );
endinterface

// File: rtl/instr_fetch_sequencer.sv
// instr_fetch_sequencer: one-hot T-state generator with built-in two-cycle IR fetch
module instr_fetch_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int T_WIDTH = 12,
  parameter int ICNT_WIDTH = 16
) (
  input logic i_clk,
  input logic i_rst_n,
  instr_fetch_sequencer_if.slave bus
);
  logic [T_WIDTH-1:0] r_t;
  logic r_halted;
  logic r_ovf;
  logic [ICNT_WIDTH-1:0] r_icnt;
  logic w_fetch;
  logic w_boundary;
  assign w_fetch = r_t[FETCH_LO] | r_t[FETCH_HI];
  // running off the last execute slot is treated as an implicit T_Reset
  assign w_boundary = bus.i_t_reset | r_t[T_WIDTH-1];
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_t <= T_WIDTH'(1);
      r_halted <= 1'b0;
      r_ovf <= 1'b0;
      r_icnt <= '0;
    end else if (!bus.i_stall) begin
      if (r_halted) begin
        if (!bus.i_halt) begin
          r_t <= T_WIDTH'(1);
          r_halted <= 1'b0;
        end
      end else if (w_fetch) begin
        r_t <= r_t << 1;
        if (r_t[FETCH_HI]) r_icnt <= r_icnt + 1'b1;
      end else if (w_boundary) begin
        if (!bus.i_t_reset) r_ovf <= 1'b1;
        r_t <= bus.i_halt ? '0 : T_WIDTH'(1);
        r_halted <= bus.i_halt;
      end else begin
        r_t <= r_t << 1;
      end
    end
  end
  always_comb begin
    bus.o_t = r_t;
    bus.o_ir_write = w_fetch & ~bus.i_stall;
    bus.o_ir_lh = r_t[FETCH_HI] ? IR_HIGH : IR_LOW;
    bus.o_mem_cs = w_fetch ? MEM_SEL : ~MEM_SEL;
    bus.o_mem_wr = 1'b0;
    bus.o_fetch_pc_inc = w_fetch & ~bus.i_stall;
    bus.o_fetch_addr_pc = w_fetch;
    bus.o_halted = r_halted;
    bus.o_seq_overflow = r_ovf;
    bus.o_instr_count = r_icnt;
  end
endmodule
